line_fetcher: RTL and testbench

LINE_FETCHER -- requirements
Module: line_fetcher

---
 rtl/line_fetcher.sv | 167 ++++++++++++++++
 tb/tb_line_fetcher.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fetcher.sv
// Double-buffered scanline fetcher: fills the back line buffer from the framebuffer one
// BEAT_PIX-pixel beat at a time and swaps it to the front at the start of its display row.
module line_fetcher #(
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned V_LINES  = 480,
  parameter int unsigned BEAT_PIX = 4
) (
  input  logic                      CLK25MHZ,
  input  logic                      ck_rst_,
  input  logic signed [11:0]        next_y,
  input  logic                      next_line,
  input  logic                      vga_vs,
  output logic                      mem_req,
  output logic [16:0]               mem_addr,
  input  logic                      mem_ack,
  input  logic [BEAT_PIX*12-1:0]    mem_data,
  output logic [H_PIXELS-1:0][11:0] line_out,
  output logic                      line_valid,
  output logic [8:0]                front_row,
  output logic                      underrun
);

  localparam int unsigned Beats = H_PIXELS / BEAT_PIX;
  localparam int unsigned BeatW = $clog2(Beats);

  typedef enum logic [1:0] {StIdle, StFetch, StFull} state_e;

  state_e                              state_q, state_d;
  logic [BeatW-1:0]                    beat_q, beat_d;
  logic [16:0]                         addr_q, addr_d;
  logic [8:0]                          back_row_q, back_row_d;
  logic [8:0]                          row_next;
  logic                                back_valid_q, back_valid_d;
  logic                                discard_q, discard_d;
  logic                                front_sel_q, front_sel_d;
  logic                                line_valid_q, line_valid_d;
  logic [8:0]                          front_row_q, front_row_d;
  logic                                underrun_q, underrun_d;
  logic                                next_line_q, vga_vs_q;
  logic                                rise, vs_fall, y_match, wr_en;
  logic [Beats-1:0][BEAT_PIX*12-1:0]   buf0_q, buf1_q;

  assign rise     = next_line && !next_line_q;
  assign vs_fall  = !vga_vs && vga_vs_q;
  // Rows outside the active area never match, even if numerically equal to back_row.
  assign y_match  = !next_y[11] && ($unsigned(next_y) < 12'(V_LINES)) &&
                    ($unsigned(next_y) == 12'(back_row_q));
  assign row_next = back_row_q + 9'd1;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    back_row_d   = back_row_q;
    back_valid_d = back_valid_q;
    discard_d    = discard_q;
    front_sel_d  = front_sel_q;
    line_valid_d = line_valid_q;
    front_row_d  = front_row_q;
    underrun_d   = underrun_q;
    wr_en        = 1'b0;

    if (rise && y_match && !back_valid_q && back_row_q != 9'd0) begin
      underrun_d = 1'b1;
    end

    if (vs_fall) begin
      back_row_d   = '0;
      back_valid_d = 1'b0;
      if (state_q != StFetch || mem_ack) begin
        state_d   = StFetch;
        beat_d    = '0;
        addr_d    = '0;
        discard_d = 1'b0;
      end else begin
        // Keep the outstanding request stable; its data is dropped when it lands.
        discard_d = 1'b1;
      end
    end else begin
      case (state_q)
        StIdle: ;
        StFetch: begin
          if (mem_ack) begin
            if (discard_q) begin
              beat_d    = '0;
              addr_d    = '0;
              discard_d = 1'b0;
            end else begin
              wr_en  = 1'b1;
              addr_d = addr_q + 17'd1;
              if (beat_q == BeatW'(Beats - 1)) begin
                beat_d       = '0;
                state_d      = StFull;
                back_valid_d = 1'b1;
              end else begin
                beat_d = beat_q + 1'b1;
              end
            end
          end
        end
        StFull: begin
          // Rows are fetched in order, so addr_q already points at row_next's first beat.
          if (rise && y_match && back_valid_q) begin
            front_sel_d  = !front_sel_q;
            front_row_d  = back_row_q;
            line_valid_d = 1'b1;
            back_valid_d = 1'b0;
            back_row_d   = row_next;
            state_d      = (32'(row_next) < V_LINES) ? StFetch : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK25MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      state_q      <= StIdle;
      beat_q       <= '0;
      addr_q       <= '0;
      back_row_q   <= '0;
      back_valid_q <= 1'b0;
      discard_q    <= 1'b0;
      front_sel_q  <= 1'b0;
      line_valid_q <= 1'b0;
      front_row_q  <= '0;
      underrun_q   <= 1'b0;
      next_line_q  <= 1'b1;
      vga_vs_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
      back_row_q   <= back_row_d;
      back_valid_q <= back_valid_d;
      discard_q    <= discard_d;
      front_sel_q  <= front_sel_d;
      line_valid_q <= line_valid_d;
      front_row_q  <= front_row_d;
      underrun_q   <= underrun_d;
      next_line_q  <= next_line;
      vga_vs_q     <= vga_vs;
    end
  end

  always_ff @(posedge CLK25MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      buf0_q <= '0;
      buf1_q <= '0;
    end else if (wr_en) begin
      if (front_sel_q) begin
        buf0_q[beat_q] <= mem_data;
      end else begin
        buf1_q[beat_q] <= mem_data;
      end
    end
  end

  assign mem_req    = (state_q == StFetch);
  assign mem_addr   = mem_req ? addr_q : '0;
  assign line_out   = front_sel_q ? buf1_q : buf0_q;
  assign line_valid = line_valid_q;
  assign front_row  = front_row_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_line_fetcher.sv
// Directed + randomized bench for line_fetcher; framebuffer contents are a hash of the address.
// V_LINES is reduced so that a complete frame at realistic line timing stays short.
module tb_line_fetcher;

  localparam int VL    = 32;
  localparam int H     = 640;
  localparam int BEATS = 160;

  logic               clk;
  logic               ck_rst_;
  logic signed [11:0] next_y;
  logic               next_line;
  logic               vga_vs;
  logic               mem_req;
  logic [16:0]        mem_addr;
  logic               mem_ack;
  logic [47:0]        mem_data;
  logic [H-1:0][11:0] line_out;
  logic               line_valid;
  logic [8:0]         front_row;
  logic               underrun;

  int                 n_tests = 0;
  int                 n_fail  = 0;
  int                 mode;      // 0: no acks, 1: ack every cycle, 2: random 0-3 latency
  int unsigned        salt;
  int                 ack_log[$];

  line_fetcher #(
    .H_PIXELS (H),
    .V_LINES  (VL),
    .BEAT_PIX (4)
  ) dut (
    .CLK25MHZ   (clk),
    .ck_rst_    (ck_rst_),
    .next_y     (next_y),
    .next_line  (next_line),
    .vga_vs     (vga_vs),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .line_out   (line_out),
    .line_valid (line_valid),
    .front_row  (front_row),
    .underrun   (underrun)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  initial begin
    #3_200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [47:0] pat(input int unsigned addr);
    logic [31:0] h;
    h = (addr + salt) * 32'h9E37_79B1;
    return {h[15:0], h ^ 32'h5A5A_C3C3};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_pixels(input string tag, input int row);
    int          pix[4];
    logic [47:0] beat;
    pix[0] = 0;
    pix[1] = 5;
    pix[2] = H - 1;
    pix[3] = int'($urandom_range(H - 1, 0));
    for (int k = 0; k < 4; k++) begin
      beat = pat(row * BEATS + pix[k] / 4);
      check($sformatf("%s_px%0d", tag, pix[k]), line_out[pix[k]], beat[12*(pix[k]%4) +: 12]);
    end
  endtask

  // Memory responder: decides the ack just after each falling edge.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req && mode != 0) begin
        if (wait_cnt == 0) begin
          mem_ack  = 1'b1;
          mem_data = pat(mem_addr);
          ack_log.push_back(int'(mem_addr));
          wait_cnt = (mode == 2) ? int'($urandom_range(3, 0)) : 0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Waits for the pending row to finish, then starts display line y.
  task automatic serve_line(input int y);
    int n;
    next_line = 1'b0;
    tick();
    n = 0;
    while (mem_req && n < 1000) begin
      tick();
      n++;
    end
    check($sformatf("fetch_done_y%0d", y), mem_req, 1'b0);
    next_y    = 12'(y);
    next_line = 1'b1;
    tick();
    check($sformatf("swap_row_y%0d", y), front_row, y);
    check_pixels($sformatf("swap_data_y%0d", y), y);
    next_line = 1'b0;
  endtask

  // One 800-cycle video line: 751 cycles of next_line high, 49 low.
  task automatic run_line(input int y, input bit vs_low, input bit chk, input int exp_front);
    next_y    = 12'(y);
    next_line = 1'b1;
    vga_vs    = !vs_low;
    tick();
    if (chk) begin
      check($sformatf("frame_front_y%0d", y), front_row, exp_front);
      check($sformatf("frame_valid_y%0d", y), line_valid, 1'b1);
      check_pixels($sformatf("frame_data_y%0d", y), exp_front);
    end
    repeat (750) tick();
    next_line = 1'b0;
    repeat (49) tick();
  endtask

  initial begin
    int n;
    int bad;
    int base;
    int stall_addr;
    salt      = $urandom;
    mode      = 0;
    ck_rst_   = 1'b0;
    next_y    = '0;
    next_line = 1'b0;
    vga_vs    = 1'b1;
    repeat (2) tick();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 17'd0);
    check("rst_line_valid", line_valid, 1'b0);
    check("rst_front_row", front_row, 9'd0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_line_out", line_out == '0, 1'b1);
    ck_rst_ = 1'b1;
    mode    = 1;
    repeat (4) tick();
    check("no_req_before_vs", mem_req, 1'b0);

    // First row fetch with an ack every cycle.
    ack_log.delete();
    vga_vs = 1'b0;
    tick();
    vga_vs = 1'b1;
    check("fetch0_req", mem_req, 1'b1);
    for (n = 0; n < 400 && mem_req; n++) tick();
    check("fetch0_done", mem_req, 1'b0);
    check("fetch0_acks", ack_log.size(), 160);
    bad = 0;
    foreach (ack_log[i]) if (ack_log[i] != i) bad++;
    check("fetch0_addr_seq", bad, 0);

    // Swap of row 0; row 1 fetch starts at 160 but is held without acks.
    mode      = 0;
    next_y    = 12'sd0;
    next_line = 1'b1;
    tick();
    check("swap0_front_row", front_row, 9'd0);
    check("swap0_line_valid", line_valid, 1'b1);
    check("swap0_px5", line_out[5], pat(1) >> 12 & 48'hFFF);
    check_pixels("swap0_data", 0);
    check("row1_req", mem_req, 1'b1);
    check("row1_addr", mem_addr, 17'd160);
    next_line = 1'b0;
    repeat (4) tick();

    // Row 0 again while back_row is 1: no swap, no underrun.
    next_line = 1'b1;
    tick();
    check("noswap_front_row", front_row, 9'd0);
    check("noswap_underrun", underrun, 1'b0);
    next_line = 1'b0;
    repeat (4) tick();

    // Row 1 requested but not fetched.
    next_y    = 12'sd1;
    next_line = 1'b1;
    tick();
    check("underrun_set", underrun, 1'b1);
    check("underrun_front_row", front_row, 9'd0);
    check("underrun_req", mem_req, 1'b1);
    check("underrun_addr", mem_addr, 17'd160);
    next_line = 1'b0;

    // Rows 1-4, then a vertical sync in the middle of row 5.
    mode = 1;
    for (int y = 1; y <= 4; y++) serve_line(y);
    base = ack_log.size();
    repeat (10) tick();
    mode = 0;
    repeat (3) tick();
    stall_addr = 5 * BEATS + (ack_log.size() - base);
    check("row5_stall_req", mem_req, 1'b1);
    check("row5_stall_addr", mem_addr, stall_addr);
    vga_vs = 1'b0;
    tick();
    vga_vs = 1'b1;
    check("vs_pending_req", mem_req, 1'b1);
    check("vs_pending_addr", mem_addr, stall_addr);
    tick();
    check("vs_pending_addr2", mem_addr, stall_addr);
    mode = 1;
    tick();
    check("vs_restart_addr", mem_addr, 17'd0);
    check("vs_restart_req", mem_req, 1'b1);
    serve_line(0);
    check("underrun_sticky", underrun, 1'b1);

    // Asynchronous reset in the middle of a fetch.
    mode = 0;
    tick();
    check("pre_rst_req", mem_req, 1'b1);
    #5 ck_rst_ = 1'b0;
    #1;
    check("async_rst_req", mem_req, 1'b0);
    check("async_rst_addr", mem_addr, 17'd0);
    check("async_rst_valid", line_valid, 1'b0);
    check("async_rst_front", front_row, 9'd0);
    check("async_rst_underrun", underrun, 1'b0);
    check("async_rst_line_out", line_out == '0, 1'b1);
    tick();
    ck_rst_ = 1'b1;
    tick();

    // Full frame with random ack latency.
    mode = 2;
    run_line(0, 1'b0, 1'b0, 0);
    run_line(0, 1'b1, 1'b0, 0);
    run_line(0, 1'b0, 1'b1, 0);
    for (int y = 0; y < VL; y++) run_line(y, 1'b0, 1'b1, y);
    run_line(0, 1'b0, 1'b1, VL - 1);
    check("frame_end_req", mem_req, 1'b0);
    check("frame_end_underrun", underrun, 1'b0);
    run_line(VL, 1'b0, 1'b1, VL - 1);
    check("out_of_range_y_underrun", underrun, 1'b0);
    run_line(-1, 1'b0, 1'b1, VL - 1);
    check("negative_y_underrun", underrun, 1'b0);
    check("idle_req", mem_req, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
